// File: rtl/rtc_read_channel.sv
// Read channel of the microcontroller interface: turns a level read request into a
// one-hot register select, captures the returned word and completes the level handshake.
module rtc_read_channel #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int SEL_W  = 31
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_reg_r_data,
    output logic [SEL_W-1:0]  o_rd_dec_addr,
    output logic [DATA_W-1:0] o_reg_r_bus,
    output logic              o_rd_valid,
    output logic              o_rd_err,
    output logic              o_rd_busy,
    output logic              o_ir_clr
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;

    localparam logic [ADDR_W-1:0] IR_ADDR = ADDR_W'(3);

    logic [2:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [SEL_W-1:0]  dec_q,    dec_d;
    logic [DATA_W-1:0] bus_q,    bus_d;
    logic              valid_q,  valid_d;
    logic              err_q,    err_d;
    logic              busy_q,   busy_d;
    logic              ir_clr_q, ir_clr_d;

    logic [SEL_W-1:0]  hit_vec;
    logic              addr_mapped;

    // Each select bit matches exactly one address; bits 18..21 have no register behind them.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_dec
            if (gi < 18) begin : g_low
                assign hit_vec[gi] = (i_addr == ADDR_W'(gi));
            end else if (gi < 22) begin : g_hole
                assign hit_vec[gi] = 1'b0;
            end else begin : g_high
                assign hit_vec[gi] = (i_addr == ADDR_W'(gi + 2));
            end
        end
    endgenerate

    assign addr_mapped = |hit_vec;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dec_d    = dec_q;
        bus_d    = bus_q;
        valid_d  = valid_q;
        err_d    = err_q;
        ir_clr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rd_en) begin
                    addr_d = i_addr;
                    if (addr_mapped) begin
                        dec_d   = hit_vec;
                        state_d = S_SELECT;
                    end else begin
                        bus_d   = '0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_SELECT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                bus_d    = i_reg_r_data;
                valid_d  = 1'b1;
                err_d    = 1'b0;
                ir_clr_d = (addr_q == IR_ADDR);
                dec_d    = '0;
                state_d  = S_DONE;
            end
            S_DONE, S_ERR: begin
                // Requester drops its level once it has seen valid; that closes the handshake.
                if (!i_rd_en) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                dec_d   = '0;
                valid_d = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            dec_q    <= '0;
            bus_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ir_clr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dec_q    <= dec_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ir_clr_q <= ir_clr_d;
        end
    end

    assign o_rd_dec_addr = dec_q;
    assign o_reg_r_bus   = bus_q;
    assign o_rd_valid    = valid_q;
    assign o_rd_err      = err_q;
    assign o_rd_busy     = busy_q;
    assign o_ir_clr      = ir_clr_q;

endmodule
